// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and constants for the NCO sweep controller
//
// Purpose: sweep FSM state encoding and the default phase-increment width
// shared with the NCO. No ports.
package nco_pkg;

  localparam int NCO_PHASE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// rtl/nco_dwell_timer.sv - loadable dwell down-counter with zero flag
//
// Purpose: counts the clocks a sweep step is held. Load wins over decrement;
// the count saturates at zero.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load_i        load value_i into the counter
//   value_i       reload value (DWELL_WIDTH)
//   dec_i         decrement by one when non-zero
//   zero_o        counter currently equals zero
module nco_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic [DWELL_WIDTH-1:0] value_i,
  input  logic                   dec_i,
  output logic                   zero_o
);

  logic [DWELL_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - NCO frequency-sweep scheduler (chirp f_start -> f_stop)
//
// Purpose: steps the NCO phase increment from f_start to f_stop by f_step,
// holding each value for the programmed dwell. Single-shot or looping sweeps.
// Build option: define NCO_SWEEP_TRIANGLE_EN for triangle looping (reverse
// direction at each end point); default looping is sawtooth (reload f_start).
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start_i, abort_i   start pulse (ignored while busy), abort pulse (wins)
//   loop_i             repeat until abort, sampled at start
//   f_start_i/f_stop_i first/final phase increment
//   f_step_i           step magnitude, dwell_i extra clocks per step
//   phi_inc_o          registered phase increment, phi_valid_o new-value pulse
//   busy_o, done_o     sweep active, single-shot completion pulse
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PHASE_WIDTH = NCO_PHASE_WIDTH,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   loop_i,
  input  logic [PHASE_WIDTH-1:0] f_start_i,
  input  logic [PHASE_WIDTH-1:0] f_stop_i,
  input  logic [PHASE_WIDTH-1:0] f_step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [PHASE_WIDTH-1:0] phi_inc_o,
  output logic                   phi_valid_o,
  output logic                   busy_o,
  output logic                   done_o
);

  sweep_state_t           state_q;
  logic [PHASE_WIDTH-1:0] phi_q, start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   loop_q, valid_q, busy_q, done_q;

  logic accept, dwell_zero, at_stop, hold_end, wrap_reload, tmr_load;
  logic [PHASE_WIDTH:0]   sum_d, diff_d;
  logic [PHASE_WIDTH-1:0] phi_step_d;

  assign accept   = (state_q == IDLE) && start_i && !abort_i;
  assign at_stop  = (phi_q == stop_q);
  assign hold_end = (state_q == HOLD) && dwell_zero;

`ifdef NCO_SWEEP_TRIANGLE_EN
  // Turn-around goes through STEP, which reloads the timer itself.
  assign wrap_reload = 1'b0;
`else
  assign wrap_reload = hold_end && at_stop && loop_q;
`endif

  assign tmr_load = accept || (state_q == STEP) || wrap_reload;

  nco_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .value_i (accept ? dwell_i : dwell_q),
    .dec_i   (state_q == HOLD),
    .zero_o  (dwell_zero)
  );

  // Next step value at PHASE_WIDTH+1 bits: anything that reaches or passes
  // f_stop, wraps, or uses a zero step lands exactly on f_stop.
  always_comb begin
    sum_d      = {1'b0, phi_q} + {1'b0, step_q};
    diff_d     = {1'b0, phi_q} - {1'b0, step_q};
    phi_step_d = stop_q;
    if (step_q != '0) begin
      if (stop_q > phi_q) begin
        if (sum_d < {1'b0, stop_q}) phi_step_d = sum_d[PHASE_WIDTH-1:0];
      end else begin
        if (!diff_d[PHASE_WIDTH] && (diff_d[PHASE_WIDTH-1:0] > stop_q))
          phi_step_d = diff_d[PHASE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phi_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        phi_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              start_q <= f_start_i;
              stop_q  <= f_stop_i;
              step_q  <= f_step_i;
              dwell_q <= dwell_i;
              loop_q  <= loop_i;
              phi_q   <= f_start_i;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (dwell_zero) begin
              if (!at_stop) begin
                state_q <= STEP;
              end else if (!loop_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
`ifdef NCO_SWEEP_TRIANGLE_EN
                start_q <= stop_q;
                stop_q  <= start_q;
                state_q <= STEP;
`else
                phi_q   <= start_q;
                valid_q <= 1'b1;
`endif
              end
            end
          end
          STEP: begin
            phi_q   <= phi_step_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign phi_inc_o   = phi_q;
  assign phi_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
